sm_hex_display: RTL and testbench

Downstream consumer of the CPU debug read-out port (`regData`) in the top level. It captures the 32-bit register value on a load strobe and shows it as 8 hex digits on a time-multiplexed 7-segment display. The block runs on the board clock `clkIn`, not the divided CPU clock, so the scan rate is independent of `clkDevide`. It contains a scan prescaler, a digit-index counter, a shadow register, leading-zero blanking and registered segment/anode outputs.

---
 rtl/sm_display_pkg.sv | 21 ++
 rtl/sm_hex_to_seg.sv | 11 +
 rtl/sm_hex_display.sv | 96 +++++++++
 tb/tb_sm_hex_display.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sm_display_pkg.sv
// Shared constants for the hex 7-segment display: digit glyph table,
// idle output values and the digit-index width helper.
package sm_display_pkg;

  // Active-high {g,f,e,d,c,b,a} glyphs for 0..F
  localparam logic [6:0] HEX7 [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Idle values in active-high sense; output polarity is applied later
  localparam logic [6:0] SEG_OFF = 7'h00;
  localparam logic       AN_OFF  = 1'b0;

  function automatic int unsigned idx_width(input int unsigned digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

  localparam int unsigned IDX_W = idx_width(8);

endpackage

// File: rtl/sm_hex_to_seg.sv
// Combinational hex nibble to active-high 7-segment decoder.
module sm_hex_to_seg
  import sm_display_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  always_comb o_seg = HEX7[i_nib];

endmodule

// File: rtl/sm_hex_display.sv
// Captures a data word on load and scans it as hex digits across a
// multiplexed 7-segment display with optional leading-zero blanking.
module sm_hex_display
  import sm_display_pkg::*;
#(
  parameter int unsigned DIGITS         = 8,
  parameter int unsigned SCAN_DIV       = 16,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clkIn,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data,
  input  logic                  load,
  input  logic                  blank,
  input  logic [DIGITS-1:0]     dp,
  output logic [6:0]            seg,
  output logic                  seg_dp,
  output logic [DIGITS-1:0]     an
);

  localparam int unsigned       W_IDX    = idx_width(DIGITS);
  localparam logic [W_IDX-1:0]  LAST_IDX = W_IDX'(DIGITS - 1);

  logic [SCAN_DIV-1:0]  r_presc;
  logic [W_IDX-1:0]     r_idx;
  logic [4*DIGITS-1:0]  r_shadow;

  logic                 w_tick;
  logic [3:0]           w_nib;
  logic [6:0]           w_hex;
  logic [6:0]           w_seg_ah;
  logic [DIGITS-1:0]    w_onehot;
  logic [DIGITS-1:0]    w_lz;
  logic                 w_run;
  logic                 w_blanked;
  logic                 w_dp;

  assign w_tick = &r_presc;

  always_ff @(posedge clkIn) begin
    if (!rst_n) begin
      r_presc  <= '0;
      r_idx    <= '0;
      r_shadow <= '0;
    end else begin
      r_presc <= r_presc + SCAN_DIV'(1);
      if (w_tick)
        r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + W_IDX'(1);
      if (load)
        r_shadow <= data;
    end
  end

  // w_lz[i]: nibbles i..DIGITS-1 are all zero (walked top-down)
  always_comb begin
    w_run     = 1'b1;
    w_lz      = '0;
    w_nib     = '0;
    w_onehot  = '0;
    w_blanked = 1'b0;
    w_dp      = 1'b0;
    for (int unsigned j = 0; j < DIGITS; j++) begin
      w_run                = w_run & (r_shadow[4*(DIGITS-1-j) +: 4] == 4'h0);
      w_lz[DIGITS-1-j]     = w_run;
    end
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (r_idx == W_IDX'(i)) begin
        w_nib       = r_shadow[4*i +: 4];
        w_onehot[i] = 1'b1;
        w_blanked   = blank && (i != 0) && w_lz[i];
        w_dp        = dp[i];
      end
    end
  end

  sm_hex_to_seg u_dec (
    .i_nib (w_nib),
    .o_seg (w_hex)
  );

  assign w_seg_ah = w_blanked ? SEG_OFF : w_hex;

  always_ff @(posedge clkIn) begin
    if (!rst_n) begin
      an     <= AN_ACTIVE_LOW  ? ~{DIGITS{AN_OFF}} : {DIGITS{AN_OFF}};
      seg    <= SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
      seg_dp <= SEG_ACTIVE_LOW;
    end else begin
      an     <= AN_ACTIVE_LOW  ? ~w_onehot : w_onehot;
      seg    <= SEG_ACTIVE_LOW ? ~w_seg_ah : w_seg_ah;
      seg_dp <= SEG_ACTIVE_LOW ? ~w_dp : w_dp;
    end
  end

endmodule

// File: tb/tb_sm_hex_display.sv
// Scoreboard bench for sm_hex_display with a fast scan (SCAN_DIV=2).
module tb_sm_hex_display;

  logic        clkIn = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data  = '0;
  logic        load  = 1'b0;
  logic        blank = 1'b0;
  logic [7:0]  dp    = '0;
  logic [6:0]  seg;
  logic        seg_dp;
  logic [7:0]  an;

  always #5 clkIn = ~clkIn;

  sm_hex_display #(
    .DIGITS         (8),
    .SCAN_DIV       (2),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clkIn  (clkIn),
    .rst_n  (rst_n),
    .data   (data),
    .load   (load),
    .blank  (blank),
    .dp     (dp),
    .seg    (seg),
    .seg_dp (seg_dp),
    .an     (an)
  );

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  int unsigned m_cnt    = 0;
  int unsigned m_idx    = 0;
  logic [31:0] m_shadow = '0;

  logic [6:0] HEX_TB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Push the expected output for the coming edge, step the model, take the edge.
  task automatic advance();
    exp_t       e;
    int         hi;
    logic [3:0] nib;
    if (!rst_n) begin
      e = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1};
    end else begin
      hi = 0;
      for (int k = 0; k < 8; k++)
        if (m_shadow[4*k +: 4] != 4'h0) hi = k;
      nib   = m_shadow[4*m_idx +: 4];
      e.an  = ~(8'h01 << m_idx);
      e.seg = (blank && (int'(m_idx) > hi)) ? 7'h7F : ~HEX_TB[nib];
      e.dp  = ~dp[m_idx];
    end
    sb.push_back(e);
    if (!rst_n) begin
      m_cnt = 0; m_idx = 0; m_shadow = '0;
    end else begin
      if (m_cnt == 3) m_idx = (m_idx == 7) ? 0 : m_idx + 1;
      m_cnt = (m_cnt + 1) % 4;
      if (load) m_shadow = data;
    end
    @(posedge clkIn);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    repeat (3) begin
      advance();
      e = sb.pop_front();
      n_checks++;
      if (an !== e.an || seg !== e.seg || seg_dp !== e.dp) begin
        n_fail++;
        $display("FAIL reset_hold an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                 an, seg, seg_dp, e.an, e.seg, e.dp);
      end
    end
    rst_n = 1'b1;
    advance();
    e = sb.pop_front();
    n_checks++;
    if (an !== 8'hFE || seg !== 7'h40 || an !== e.an || seg !== e.seg) begin
      n_fail++;
      $display("FAIL reset_release an=%h seg=%h required an=fe seg=40", an, seg);
    end
  endtask

  task automatic test_hex_scan();
    exp_t e;
    blank = 1'b0; data = 32'h1234_ABCD; load = 1'b1;
    for (int c = 0; c < 40; c++) begin
      advance();
      load = 1'b0;
      e = sb.pop_front();
      n_checks++;
      if (an !== e.an || seg !== e.seg || seg_dp !== e.dp) begin
        n_fail++;
        $display("FAIL hex_scan c=%0d an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                 c, an, seg, seg_dp, e.an, e.seg, e.dp);
      end
    end
  endtask

  task automatic test_blanking();
    exp_t e;
    data = 32'h0000_00A5; load = 1'b1; blank = 1'b1;
    for (int c = 0; c < 68; c++) begin
      advance();
      load = 1'b0;
      if (c == 33) blank = 1'b0;
      e = sb.pop_front();
      n_checks++;
      if (an !== e.an || seg !== e.seg || seg_dp !== e.dp) begin
        n_fail++;
        $display("FAIL blanking c=%0d blank=%b an=%h seg=%h required an=%h seg=%h",
                 c, blank, an, seg, e.an, e.seg);
      end
    end
  endtask

  task automatic test_zero_dp();
    exp_t e;
    data = 32'h0; load = 1'b1; blank = 1'b1; dp = 8'h01;
    for (int c = 0; c < 36; c++) begin
      advance();
      load = 1'b0;
      e = sb.pop_front();
      n_checks++;
      if (an !== e.an || seg !== e.seg || seg_dp !== e.dp) begin
        n_fail++;
        $display("FAIL zero_dp c=%0d an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                 c, an, seg, seg_dp, e.an, e.seg, e.dp);
      end
    end
    dp = 8'h00;
  endtask

  task automatic test_load_on_tick();
    exp_t e;
    blank = 1'b0;
    while (m_cnt != 3) begin
      advance();
      e = sb.pop_front();
      n_checks++;
      if (an !== e.an || seg !== e.seg) begin
        n_fail++;
        $display("FAIL pre_tick an=%h seg=%h required an=%h seg=%h", an, seg, e.an, e.seg);
      end
    end
    data = 32'hFFFF_FFFF; load = 1'b1;
    advance();
    load = 1'b0;
    e = sb.pop_front();
    n_checks++;
    if (an !== e.an || seg !== e.seg) begin
      n_fail++;
      $display("FAIL tick_edge an=%h seg=%h required an=%h seg=%h", an, seg, e.an, e.seg);
    end
    advance();
    e = sb.pop_front();
    n_checks++;
    if (seg !== 7'h0E || an !== e.an || seg !== e.seg) begin
      n_fail++;
      $display("FAIL load_tick_new an=%h seg=%h required an=%h seg=0e", an, seg, e.an);
    end
    while (m_cnt != 1) begin
      advance();
      e = sb.pop_front();
      n_checks++;
      if (an !== e.an || seg !== e.seg) begin
        n_fail++;
        $display("FAIL pre_reset an=%h seg=%h required an=%h seg=%h", an, seg, e.an, e.seg);
      end
    end
    rst_n = 1'b0;
    advance();
    e = sb.pop_front();
    n_checks++;
    if (an !== 8'hFF || seg !== 7'h7F || seg_dp !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset an=%h seg=%h dp=%b required an=ff seg=7f dp=1", an, seg, seg_dp);
    end
    rst_n = 1'b1;
    advance();
    e = sb.pop_front();
    n_checks++;
    if (an !== e.an || seg !== e.seg) begin
      n_fail++;
      $display("FAIL post_reset an=%h seg=%h required an=%h seg=%h", an, seg, e.an, e.seg);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [31:0] vals [3] = '{32'h1111_1111, 32'h2222_2222, 32'h89E7_6F01};
    blank = 1'b1; dp = 8'hA5;
    load = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (c < 3) data = vals[c];
      else load = 1'b0;
      advance();
      e = sb.pop_front();
      n_checks++;
      if (an !== e.an || seg !== e.seg || seg_dp !== e.dp) begin
        n_fail++;
        $display("FAIL back_to_back c=%0d an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                 c, an, seg, seg_dp, e.an, e.seg, e.dp);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_hex_scan();
    test_blanking();
    test_zero_dp();
    test_load_on_tick();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
